key_debounce_pulse: RTL
=======================

Name: key_debounce_pulse

Overview:
- Front-end conditioning stage for DE1-SoC push-buttons and slide switches, clocked by CLOCK_50.
- Sits directly upstream of the team's D flip-flop and register blocks.
- Per channel: synchronises the raw input, normalises polarity, rejects bounce, and emits a clean level plus one-cycle rise and fall pulses.
- Downstream flops use these outputs as data, enable, or reset sources instead of raw SW/KEY.

Parameters:
- N, 4: number of independent input channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to accept a change (20 ms at 50 MHz). Legal range 2 to 2^24-1.
- ACTIVE_LOW, 1: 1 means raw 0 = pressed (KEY); 0 means raw 1 = pressed/on (SW).

Ports:
- clock  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- raw_in  in  N  unsynchronised button/switch inputs.
- level  out  N  debounced, polarity-normalised state (1 = pressed/on).
- rise_pulse  out  N  one-cycle pulse when level goes 0->1.
- fall_pulse  out  N  one-cycle pulse when level goes 1->0.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock. All state updates on posedge clock. Reset acts immediately, independent of clock.
- Reset values:
  - Synchroniser flops take the released raw value: 1 if ACTIVE_LOW, else 0.
  - level=0, rise_pulse=0, fall_pulse=0, counters=0, all FSMs in RELEASED.
- Synchroniser: two flops per channel, reset as above. s = sync2 XOR ACTIVE_LOW.
- Counter: width CNT_W = clog2(DEBOUNCE_CYCLES+1), derived as a localparam. Never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- Per-channel FSM, states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - RELEASED: s=1 -> PRESS_WAIT, cnt<=1. Otherwise stay, cnt<=0.
  - PRESS_WAIT, s=0 -> RELEASED, cnt<=0 (glitch rejected, no pulse).
  - PRESS_WAIT, s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, level<=1, rise_pulse<=1, cnt<=0.
  - PRESS_WAIT, s=1 otherwise: cnt<=cnt+1.
  - PRESSED, RELEASE_WAIT: mirror images with s inverted. Acceptance sets level<=0 and fall_pulse<=1.
- Pulses are registered and high for exactly one cycle. They default to 0 on every cycle without an acceptance.
- Latency: let E0 be the first clock edge sampling a new stable raw value. level changes, and the pulse asserts, on edge E0+DEBOUNCE_CYCLES+1. The pulse deasserts on the following edge.
- Bounce: any reversal of s during a WAIT state restarts from the stable state. Reversals shorter than DEBOUNCE_CYCLES samples produce no output activity.
- Channels are fully independent. Multiple channels may pulse in the same cycle. rise_pulse and fall_pulse of one channel are never high together.
- Reset mid-debounce discards the partial count, and any pulse in flight drops immediately.
- If a button is held through reset release, it is debounced from RELEASED. It produces level=1 and one rise_pulse at edge DEBOUNCE_CYCLES+1 after the first post-reset sampling edge.
- Outputs never go X after reset. raw_in X is not propagated past the synchroniser in the bench model.

Decomposition:
- Shared package/header board_io_pkg:
  - 2-bit FSM state encodings: RELEASED=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3.
  - CLK_HZ=50_000_000.
  - Helper constant DEBOUNCE_20MS=1_000_000.
- Sub-module debounce_channel (one synchroniser, counter, and FSM), instantiated N times by a generate loop in key_debounce_pulse.

Test Plan (N=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1 unless noted):
- Clean press: raw_in[0] 1->0 before edge E0, held -> level[0]=1 and rise_pulse[0]=1 after edge E0+9. Pulse is 0 after E0+10. Other channels stay 0.
- Bounce: raw_in[1] toggles 0/1 every 3 cycles for 30 cycles, then held 0 -> no pulse during bouncing. Exactly one rise_pulse[1], 9 edges after the final stable sample begins.
- Release: from pressed, raw_in[0] 0->1 held -> fall_pulse[0] one cycle and level[0]=0 at E0+9. rise_pulse[0] never asserted.
- Glitch: raw_in[2] low for 7 cycles, then high -> level[2], rise_pulse[2], fall_pulse[2] all remain 0.
- Reset mid-operation: assert reset at cnt=5 with raw_in[3]=0 held, release after 3 cycles -> outputs 0 immediately. One rise_pulse[3] at edge 9 after the first post-reset sampling edge.
- ACTIVE_LOW=0, simultaneous: raw_in=4'b1111 at E0 -> level=4'b1111 and rise_pulse=4'b1111 in the same cycle at E0+9.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared constants for the DE1-SoC board I/O conditioning blocks.
// Debounce FSM state encodings are plain constants so older blocks can reuse them.
package board_io_pkg;

   localparam logic [1:0] ST_RELEASED     = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_PRESSED      = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   localparam int unsigned CLK_HZ        = 50_000_000;
   localparam int unsigned DEBOUNCE_20MS = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchroniser, polarity normalisation, debounce FSM
// with a stability counter, and registered one-cycle rise/fall pulses.
module debounce_channel
   import board_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_in,
   output logic level,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_q, sync2_q;
   logic             s;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   // NOTE: the synchroniser resets to the released raw level, so an idle input
   // does not look like a press right after reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= ACTIVE_LOW;
         sync2_q <= ACTIVE_LOW;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q ^ ACTIVE_LOW;

   // NOTE: every signal gets a default before the case so no latch is inferred;
   // pulses default low and are only raised on an accepted change.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         ST_RELEASED: begin
            if (s) begin
               state_d = ST_PRESS_WAIT;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!s) begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_PRESSED;
               level_d = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_PRESSED: begin
            if (!s) begin
               state_d = ST_RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         ST_RELEASE_WAIT: begin
            if (s) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_RELEASED;
               level_d = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_RELEASED;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level      = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule

// File: rtl/key_debounce_pulse.sv
// N independent debounce channels for DE1-SoC KEY/SW inputs, producing clean
// levels and one-cycle edge pulses for downstream flops.
module key_debounce_pulse
   import board_io_pkg::*;
#(
   parameter int          N               = 4,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] raw_in,
   output logic [N-1:0] level,
   output logic [N-1:0] rise_pulse,
   output logic [N-1:0] fall_pulse
);

   for (genvar g = 0; g < N; g++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_chan (
         .clock      (clock),
         .reset      (reset),
         .raw_in     (raw_in[g]),
         .level      (level[g]),
         .rise_pulse (rise_pulse[g]),
         .fall_pulse (fall_pulse[g])
      );
   end

endmodule
